// File: rtl/gb_cart_pkg.sv
// Shared constants and types for the cartridge bank controller.
package gb_cart_pkg;
  typedef enum logic {MBC_NONE = 1'b0, MBC1 = 1'b1} mbc_type_e;

  localparam logic [15:0] ROM0_BASE = 16'h0000;
  localparam logic [15:0] ROMX_BASE = 16'h4000;
  localparam logic [15:0] ERAM_BASE = 16'hA000;
  localparam logic [15:0] ERAM_END  = 16'hBFFF;

  localparam int BANK1_W = 5;
  localparam int BANK2_W = 2;

  localparam logic [3:0] RAM_KEY = 4'hA;
endpackage

// File: rtl/gb_mbc1_regs.sv
// MBC1 write-event detector and bank/mode/enable registers.
module gb_mbc1_regs
  import gb_cart_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         addr_hi,
  input  logic [7:0]         wdata,
  input  logic               wr_n,
  output logic               wr_evt,
  output logic [BANK1_W-1:0] bank1,
  output logic [BANK2_W-1:0] bank2,
  output logic               mode,
  output logic               ram_en
);
  logic wr_n_q;
  logic unused_hi;

  assign unused_hi = ^wdata[7:5];
  assign wr_evt    = !wr_n && wr_n_q && !reset;

  // wr_n_q keeps tracking the strobe while in reset so a write held low across reset release is not replayed
  always_ff @(posedge clock) begin
    wr_n_q <= wr_n;
    if (reset) begin
      bank1  <= BANK1_W'(1);
      bank2  <= '0;
      mode   <= 1'b0;
      ram_en <= 1'b0;
    end else if (EN && wr_evt && !addr_hi[2]) begin
      case (addr_hi[1:0])
        2'd0: ram_en <= (wdata[3:0] == RAM_KEY);
        2'd1: bank1  <= (wdata[BANK1_W-1:0] == '0) ? BANK1_W'(1) : wdata[BANK1_W-1:0];
        2'd2: bank2  <= wdata[BANK2_W-1:0];
        default: mode <= wdata[0];
      endcase
    end
  end
endmodule

// File: rtl/gb_cart_mbc.sv
// Cartridge bank controller: ROM/RAM address generation and CPU read-data mux.
module gb_cart_mbc
  import gb_cart_pkg::*;
#(
  parameter int MBC_TYPE  = 1,
  parameter int ROM_BANKS = 64,
  parameter int RAM_BANKS = 4,
  localparam int ROM_BW   = $clog2(ROM_BANKS),
  localparam int ROM_AW   = ROM_BW + 14,
  localparam int RAM_BW   = (RAM_BANKS > 1) ? $clog2(RAM_BANKS) : 0,
  localparam int RAM_AW   = RAM_BW + 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       A,
  input  logic [7:0]        Do,
  input  logic              wr_n,
  input  logic              rd_n,
  input  logic              cs_n,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_data,
  output logic [7:0]        Di,
  output logic              cart_hit
);
  localparam bit HAS_MBC = (MBC_TYPE == int'(MBC1));
  localparam bit HAS_RAM = (RAM_BANKS != 0);

  logic               wr_evt;
  logic [BANK1_W-1:0] bank1;
  logic [BANK2_W-1:0] bank2;
  logic               mode;
  logic               ram_en;
  logic [BANK1_W+BANK2_W-1:0] rom_bank, rom_bank_m;
  logic [BANK2_W-1:0] ram_bank_m;
  logic               eram, ram_en_eff;
  logic               unused_ok;

  gb_mbc1_regs #(.EN(HAS_MBC)) u_regs (
    .clock   (clock),
    .reset   (reset),
    .addr_hi (A[15:13]),
    .wdata   (Do),
    .wr_n    (wr_n),
    .wr_evt  (wr_evt),
    .bank1   (bank1),
    .bank2   (bank2),
    .mode    (mode),
    .ram_en  (ram_en)
  );

  // Fixed window bank is 0 unless mode 1 routes bank2 into the upper bits
  always_comb begin
    rom_bank = {bank2, bank1};
    if (A < ROMX_BASE || (A >= 16'h8000 && !A[14]))
      rom_bank = mode ? {bank2, {BANK1_W{1'b0}}} : '0;
  end

  assign rom_bank_m = rom_bank & (BANK1_W+BANK2_W)'(ROM_BANKS - 1);
  assign ram_bank_m = (HAS_MBC && mode) ? (bank2 & BANK2_W'(RAM_BANKS - 1)) : '0;

  if (HAS_MBC) begin : g_rom_mbc
    assign rom_addr = {rom_bank_m[ROM_BW-1:0], A[13:0]};
  end else begin : g_rom_flat
    assign rom_addr = ROM_AW'(A[14:0]);
  end

  if (RAM_BW > 0) begin : g_ram_bank
    assign ram_addr = {ram_bank_m[RAM_BW-1:0], A[12:0]};
  end else begin : g_ram_flat
    assign ram_addr = A[12:0];
  end

  assign eram       = !cs_n && (A >= ERAM_BASE) && (A <= ERAM_END);
  assign ram_en_eff = HAS_RAM && (HAS_MBC ? ram_en : 1'b1);
  assign ram_we     = wr_evt && eram && ram_en_eff;
  assign ram_wdata  = Do;
  assign cart_hit   = !A[15] || ((A >= ERAM_BASE) && (A <= ERAM_END));

  always_comb begin
    Di = 8'hFF;
    if (!A[15])
      Di = rom_data;
    else if (eram && ram_en_eff)
      Di = ram_data;
  end

  assign unused_ok = ^{rd_n, rom_bank_m, ram_bank_m, bank1, bank2, mode, ram_en};
endmodule

// File: tb/tb_gb_cart_mbc.sv
// Bench: three controller builds (MBC1/64, MBC1/128, ROM-only) against a bus-level model.
module tb_gb_cart_mbc;
  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] A;
  logic [7:0]  Do;
  logic        wr_n, rd_n, cs_n;

  always #5 clock = ~clock;

  logic [19:0] rom_addr0; logic [14:0] ram_addr0;
  logic [20:0] rom_addr1; logic [14:0] ram_addr1;
  logic [14:0] rom_addr2; logic [12:0] ram_addr2;
  logic [7:0]  rom_data0, rom_data1, rom_data2, ram_data0, ram_data1, ram_data2;
  logic [7:0]  wd0, wd1, wd2, di0, di1, di2;
  logic        we0, we1, we2, hit0, hit1, hit2;

  function automatic logic [7:0] romfn(input logic [31:0] x);
    return x[7:0] ^ x[15:8] ^ x[23:16] ^ 8'h5A;
  endfunction

  assign rom_data0 = romfn(32'(rom_addr0));
  assign rom_data1 = romfn(32'(rom_addr1));
  assign rom_data2 = romfn(32'(rom_addr2));

  logic [7:0] mem0[32768], mem1[32768], mem2[8192];
  int we_cnt[3];
  assign ram_data0 = mem0[ram_addr0];
  assign ram_data1 = mem1[ram_addr1];
  assign ram_data2 = mem2[ram_addr2];
  always @(posedge clock) begin
    if (we0) begin mem0[ram_addr0] <= wd0; we_cnt[0] <= we_cnt[0] + 1; end
    if (we1) begin mem1[ram_addr1] <= wd1; we_cnt[1] <= we_cnt[1] + 1; end
    if (we2) begin mem2[ram_addr2] <= wd2; we_cnt[2] <= we_cnt[2] + 1; end
  end

  gb_cart_mbc #(.MBC_TYPE(1), .ROM_BANKS(64), .RAM_BANKS(4)) u0 (
    .clock(clock), .reset(reset), .A(A), .Do(Do), .wr_n(wr_n), .rd_n(rd_n), .cs_n(cs_n),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .ram_addr(ram_addr0), .ram_wdata(wd0),
    .ram_we(we0), .ram_data(ram_data0), .Di(di0), .cart_hit(hit0));
  gb_cart_mbc #(.MBC_TYPE(1), .ROM_BANKS(128), .RAM_BANKS(4)) u1 (
    .clock(clock), .reset(reset), .A(A), .Do(Do), .wr_n(wr_n), .rd_n(rd_n), .cs_n(cs_n),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .ram_addr(ram_addr1), .ram_wdata(wd1),
    .ram_we(we1), .ram_data(ram_data1), .Di(di1), .cart_hit(hit1));
  gb_cart_mbc #(.MBC_TYPE(0), .ROM_BANKS(2), .RAM_BANKS(1)) u2 (
    .clock(clock), .reset(reset), .A(A), .Do(Do), .wr_n(wr_n), .rd_n(rd_n), .cs_n(cs_n),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .ram_addr(ram_addr2), .ram_wdata(wd2),
    .ram_we(we2), .ram_data(ram_data2), .Di(di2), .cart_hit(hit2));

  function automatic logic [31:0] g_rom(int k);
    case (k) 0: return 32'(rom_addr0); 1: return 32'(rom_addr1); default: return 32'(rom_addr2); endcase
  endfunction
  function automatic logic [31:0] g_ram(int k);
    case (k) 0: return 32'(ram_addr0); 1: return 32'(ram_addr1); default: return 32'(ram_addr2); endcase
  endfunction
  function automatic logic [31:0] g_di(int k);
    case (k) 0: return 32'(di0); 1: return 32'(di1); default: return 32'(di2); endcase
  endfunction
  function automatic logic [31:0] g_we(int k);
    case (k) 0: return 32'(we0); 1: return 32'(we1); default: return 32'(we2); endcase
  endfunction
  function automatic logic [31:0] g_hit(int k);
    case (k) 0: return 32'(hit0); 1: return 32'(hit1); default: return 32'(hit2); endcase
  endfunction
  function automatic logic [31:0] g_wd(int k);
    case (k) 0: return 32'(wd0); 1: return 32'(wd1); default: return 32'(wd2); endcase
  endfunction

  // Reference model: bank registers as plain integers, cartridge RAM as a shadow array
  int nrom[3] = '{64, 128, 2};
  int nram[3] = '{4, 4, 1};
  bit mbc[3]  = '{1'b1, 1'b1, 1'b0};
  int m_b1[3], m_b2[3], m_mode[3], m_en[3];
  logic [7:0] m_ram[3][32768];
  bit         m_wv[3][32768];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin m_b1[k] = 1; m_b2[k] = 0; m_mode[k] = 0; m_en[k] = 0; end
  endtask

  function automatic int exp_rom(int k, int a);
    int bank, off;
    off = a % 32768;
    if (!mbc[k]) return off;
    if (off < 16384) bank = m_mode[k] ? m_b2[k] * 32 : 0;
    else             bank = m_b2[k] * 32 + m_b1[k];
    bank = bank % nrom[k];
    return bank * 16384 + (off % 16384);
  endfunction

  function automatic int exp_ram(int k, int a);
    int bank;
    bank = (mbc[k] && m_mode[k] != 0) ? m_b2[k] : 0;
    if (nram[k] > 1) bank = bank % nram[k]; else bank = 0;
    return bank * 8192 + (a % 8192);
  endfunction

  function automatic bit exp_en(int k);
    return nram[k] != 0 && (mbc[k] ? m_en[k] != 0 : 1'b1);
  endfunction

  function automatic bit in_eram(int a, bit cs);
    return !cs && a >= 'hA000 && a <= 'hBFFF;
  endfunction

  task automatic model_write(int k, int a, int d);
    if (in_eram(a, 1'b0) && exp_en(k)) begin
      m_ram[k][exp_ram(k, a)] = 8'(d);
      m_wv[k][exp_ram(k, a)]  = 1'b1;
    end
    if (mbc[k] && a < 'h8000) begin
      case (a / 8192)
        0: m_en[k] = ((d % 16) == 10) ? 1 : 0;
        1: m_b1[k] = ((d % 32) == 0) ? 1 : d % 32;
        2: m_b2[k] = d % 4;
        default: m_mode[k] = d % 2;
      endcase
    end
  endtask

  int errs = 0, checks = 0;

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d]: got %h want %h (A=%h)", nm, k, act, exp, A);
    end
  endtask

  task automatic check_all();
    int a, ra;
    a = int'(A);
    for (int k = 0; k < 3; k++) begin
      chk("rom_addr", k, g_rom(k), 32'(exp_rom(k, a)));
      chk("ram_addr", k, g_ram(k), 32'(exp_ram(k, a)));
      chk("cart_hit", k, g_hit(k), 32'(a < 'h8000 || (a >= 'hA000 && a <= 'hBFFF)));
      if (a < 'h8000) chk("di_rom", k, g_di(k), 32'(romfn(32'(exp_rom(k, a)))));
      else if (in_eram(a, cs_n)) begin
        ra = exp_ram(k, a);
        if (!exp_en(k)) chk("di_ram_off", k, g_di(k), 32'hFF);
        else if (m_wv[k][ra]) chk("di_ram", k, g_di(k), 32'(m_ram[k][ra]));
      end else chk("di_idle", k, g_di(k), 32'hFF);
    end
  endtask

  task automatic do_read(logic [15:0] a, bit cs);
    @(negedge clock);
    A = a; cs_n = cs; wr_n = 1'b1; rd_n = 1'b0;
    #1 check_all();
  endtask

  task automatic do_write(logic [15:0] a, logic [7:0] d, int hold);
    int c0[3];
    bit ew[3];
    @(negedge clock);
    A = a; Do = d; cs_n = 1'b0; rd_n = 1'b1; wr_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      c0[k] = we_cnt[k];
      ew[k] = in_eram(int'(a), 1'b0) && exp_en(k);
      chk("ram_we", k, g_we(k), 32'(ew[k]));
      chk("ram_wdata", k, g_wd(k), 32'(d));
      if (ew[k]) chk("wr_ram_addr", k, g_ram(k), 32'(exp_ram(k, int'(a))));
      model_write(k, int'(a), int'(d));
    end
    for (int h = 1; h < hold; h++) begin
      @(negedge clock);
      #1 for (int k = 0; k < 3; k++) chk("ram_we_held", k, g_we(k), 32'h0);
    end
    @(negedge clock);
    wr_n = 1'b1;
    #1 for (int k = 0; k < 3; k++) chk("we_pulses", k, 32'(we_cnt[k] - c0[k]), 32'(ew[k]));
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
    int          hold;
    logic [31:0] e_rom0, e_rom1;
    bit          chk_di;
    logic [7:0]  e_di0;
  } vec_t;
  vec_t tbl[$];

  task automatic pr(logic [15:0] a, logic [31:0] r0, logic [31:0] r1, bit cd, logic [7:0] di);
    vec_t v;
    v.wr = 1'b0; v.a = a; v.d = 8'h00; v.hold = 0; v.e_rom0 = r0; v.e_rom1 = r1;
    v.chk_di = cd; v.e_di0 = di;
    tbl.push_back(v);
  endtask
  task automatic pw(logic [15:0] a, logic [7:0] d, int hold);
    vec_t v;
    v.wr = 1'b1; v.a = a; v.d = d; v.hold = hold; v.e_rom0 = 0; v.e_rom1 = 0;
    v.chk_di = 1'b0; v.e_di0 = 8'h00;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    for (int k = 0; k < 3; k++) for (int i = 0; i < 32768; i++) m_wv[k][i] = 1'b0;
    reset = 1'b1; A = 16'h0000; Do = 8'h00; wr_n = 1'b1; rd_n = 1'b1; cs_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_rom_addr", 0, g_rom(0), 32'h0);
    chk("rst_di", 0, g_di(0), 32'(romfn(32'h0)));
    chk("rst_we", 0, g_we(0), 32'h0);
    check_all();

    pr(16'h0150, 32'h00150, 32'h00150, 1'b1, romfn(32'h00150));
    pr(16'h4150, 32'h04150, 32'h04150, 1'b1, romfn(32'h04150));
    pw(16'h2000, 8'h05, 1);
    pr(16'h4000, 32'h14000, 32'h14000, 1'b1, romfn(32'h14000));
    pw(16'h2000, 8'h00, 1);
    pr(16'h4000, 32'h04000, 32'h04000, 1'b1, romfn(32'h04000));
    pw(16'h2000, 8'h20, 1);
    pr(16'h4000, 32'h04000, 32'h04000, 1'b1, romfn(32'h04000));
    pw(16'h4000, 8'h02, 1);
    pw(16'h6000, 8'h01, 1);
    pr(16'h0000, 32'h00000, 32'h100000, 1'b1, romfn(32'h00000));
    pr(16'h4000, 32'h04000, 32'h104000, 1'b1, romfn(32'h04000));
    pr(16'hA000, 32'h0, 32'h0, 1'b1, 8'hFF);
    pw(16'hA000, 8'h55, 1);
    pw(16'h6000, 8'h00, 1);
    pw(16'h4000, 8'h00, 1);
    pw(16'h0000, 8'h0A, 1);
    pw(16'hA123, 8'h3C, 3);
    pr(16'hA123, 32'h0, 32'h0, 1'b1, 8'h3C);
    pw(16'h0000, 8'h00, 1);
    pr(16'hA123, 32'h0, 32'h0, 1'b1, 8'hFF);
    pr(16'hC000, 32'h0, 32'h0, 1'b1, 8'hFF);
    pr(16'h8000, 32'h0, 32'h0, 1'b1, 8'hFF);

    foreach (tbl[i]) begin
      if (tbl[i].wr) do_write(tbl[i].a, tbl[i].d, tbl[i].hold);
      else begin
        do_read(tbl[i].a, 1'b0);
        if (tbl[i].a < 16'h8000) begin
          chk("tbl_rom0", i, g_rom(0), tbl[i].e_rom0);
          chk("tbl_rom1", i, g_rom(1), tbl[i].e_rom1);
        end
        if (tbl[i].chk_di) chk("tbl_di0", i, g_di(0), 32'(tbl[i].e_di0));
      end
    end

    // wr_n held low while A and Do change: only the first cycle counts
    @(negedge clock);
    A = 16'h2000; Do = 8'h03; cs_n = 1'b0; wr_n = 1'b0;
    for (int k = 0; k < 3; k++) model_write(k, 'h2000, 'h03);
    @(negedge clock); A = 16'h2001; Do = 8'h09;
    @(negedge clock); A = 16'h4000; Do = 8'h03;
    repeat (2) @(negedge clock);
    wr_n = 1'b1;
    do_read(16'h4000, 1'b0);
    chk("held_bank1", 0, g_rom(0), 32'h0C000);

    // Reset landing on a write event, with wr_n still low after release
    do_write(16'h0000, 8'h0A, 1);
    @(negedge clock);
    A = 16'hA100; Do = 8'h77; wr_n = 1'b0; reset = 1'b1;
    #1 for (int k = 0; k < 3; k++) chk("rst_we_forced", k, g_we(k), 32'h0);
    @(negedge clock); A = 16'h2000; Do = 8'h07;
    @(negedge clock); reset = 1'b0;
    model_reset();
    #1 for (int k = 0; k < 3; k++) chk("post_rst_we", k, g_we(k), 32'h0);
    @(negedge clock);
    wr_n = 1'b1;
    do_read(16'h4000, 1'b0);
    chk("rst_bank1", 0, g_rom(0), 32'h04000);
    do_read(16'hA100, 1'b0);
    do_write(16'h2000, 8'h06, 1);
    do_read(16'h4000, 1'b0);
    chk("post_rst_wr", 0, g_rom(0), 32'h18000);

    for (int it = 0; it < 400; it++) begin
      ra = 16'hA000 + 16'($urandom_range(0, 7)) + 16'h1000 * 16'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0, 1: do_write(16'($urandom_range(0, 16'h7FFF)), 8'($urandom), $urandom_range(1, 2));
        2:    do_write(ra, 8'($urandom), 1);
        3:    do_read(16'($urandom), 1'($urandom_range(0, 3) == 0));
        default: do_read(ra, 1'b0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
